fsm_bspd_param: RTL and testbench
=================================

# fsm_bspd_param

Parametrised serial bitstream pattern detector. It compares an incoming serial bit stream, qualified by a valid strobe, against a runtime-loadable PAT_W-bit pattern. A match produces a one-cycle registered detect pulse. Overlap handling is selectable, and a saturating match counter is kept. It sits directly behind the serial receive path and feeds downstream framing/control logic.

## Interface
- PAT_W, 4: pattern length in bits (2..16).
- PAT_RST, 4'b1101: pattern register value after reset; width PAT_W.
- CNT_W, 8: match counter width (>=2).

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for this cycle.
- pat_load  input  1  loads pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern; MSB is the first (oldest) bit received.
- overlap_en  input  1  1 = overlapping matches allowed, 0 = history restarts after each match.
- cnt_clr  input  1  clears match_cnt and cnt_sat.
- det_out  output  1  one-cycle match pulse, registered.
- match_cnt  output  CNT_W  number of matches since reset/clear, saturating.
- cnt_sat  output  1  sticky flag, set when match_cnt reaches all-ones.

## Operation
- Internal state:
  - pat register (PAT_W).
  - hist shift register (PAT_W).
  - fill counter (0..PAT_W).
  - FSM with two states: FILL (fill < PAT_W) and ARMED (fill = PAT_W).
- Reset, synchronous, wins over everything:
  - pat=PAT_RST, hist=0, fill=0, state FILL.
  - det_out=0, match_cnt=0, cnt_sat=0.
- Priority per edge: reset > pat_load > bit_valid.
- pat_load=1:
  - pat<=pat_in, hist<=0, fill<=0, state FILL, det_out<=0.
  - bit_valid ignored that cycle.
- bit_valid=1 (no pat_load):
  - hist<={hist[PAT_W-2:0],bit_in}.
  - fill increments, saturating at PAT_W.
- Match: the shifted value {hist[PAT_W-2:0],bit_in} equals pat, with fill>=PAT_W-1 before the shift (at least PAT_W valid bits seen since last clear).
- On match:
  - det_out<=1.
  - overlap_en=1: fill stays/saturates at PAT_W; state ARMED.
  - overlap_en=0: fill<=0, hist<=0; state FILL.
- det_out<=0 on every edge without a match, including cycles with bit_valid=0.
- FSM transitions:
  - FILL->ARMED when fill reaches PAT_W without a non-overlap match.
  - ARMED->FILL on pat_load, reset, or a non-overlap match.
  - No other transitions.
- overlap_en is sampled on the matching edge only; changing it mid-stream does not alter the history.
- Counter:
  - Match increments match_cnt unless it is all-ones.
  - cnt_sat<=1 when the value written is all-ones; it stays set until cnt_clr or reset.
  - cnt_clr=1 forces match_cnt=0 and cnt_sat=0. Clear wins over a simultaneous match (the count is lost), but det_out still pulses.
- pat_load does not affect match_cnt or cnt_sat.

## Timing
- Latency: det_out is high in the cycle after the edge that samples the final pattern bit; width is exactly one cycle per match.
- Back-to-back matches in overlap mode give det_out high on consecutive cycles (e.g. pattern 1111 fed continuous 1s).
- match_cnt and cnt_sat update on the same edge as det_out.
- Gaps in bit_valid of any length do not disturb history.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, default pattern 1101; feed valid bits 1,1,0,1 on consecutive cycles -> det_out=1 for one cycle after the 4th bit; match_cnt=1; no pulse earlier.
- Load 1010, overlap_en=1, feed 1,0,1,0,1,0,1,0 -> pulses after bits 4, 6, 8, match_cnt=3. Repeat with overlap_en=0 -> pulses after bits 4 and 8 only, match_cnt=2.
- Pattern 1101, feed 1,1 then bit_valid=0 for 5 cycles, then 0,1 -> single pulse after the final bit; det_out=0 throughout the gap.
- Pattern 0000: feed three 0s, assert pat_load with pat_in=0000, then feed 0s -> no pulse until the 4th 0 after the load.
- CNT_W=2, overlap on, pattern 11, feed six 1s -> 5 pulses; match_cnt sticks at 3; cnt_sat=1 from the 3rd match. Then assert cnt_clr on the same edge as a match -> match_cnt=0, cnt_sat=0, det_out pulses.
- Assert reset after three matching bits of 1101, then feed 1 -> no pulse. pat returns to 1101, all outputs are 0 the cycle after reset, and a full 1,1,0,1 is required to match.

Source files
------------

// File: rtl/fsm_bspd_param.sv
// Serial bitstream pattern detector: matches a runtime-loadable PAT_W-bit pattern against a
// valid-qualified bit stream, with selectable overlap and a saturating match counter.
module fsm_bspd_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             det_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int             FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_MAX  = FW'(PAT_W);
    localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // The oldest history bit falls off during the compare, so only PAT_W-1 bits are stored.
    logic [PAT_W-2:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shifted;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_inc;
    state_t           state_q;
    logic             det_q;
    logic             sat_q;
    logic             match;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        shifted  = {hist_q, bit_in};
        fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
        cnt_inc  = cnt_q + 1'b1;
        // Enough history exists once armed, or when this bit is the last one needed.
        match    = !pat_load && bit_valid
                   && ((state_q == S_ARMED) || (fill_q == FILL_LAST))
                   && (shifted == pat_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_FILL;
            det_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads pre-edge state consistently.
            det_q <= match;

            if (pat_load) begin
                pat_q   <= pat_in;
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= S_FILL;
            end else if (bit_valid) begin
                if (match && !overlap_en) begin
                    hist_q  <= '0;
                    fill_q  <= '0;
                    state_q <= S_FILL;
                end else begin
                    hist_q  <= shifted[PAT_W-2:0];
                    fill_q  <= fill_inc;
                    state_q <= (fill_inc == FILL_MAX) ? S_ARMED : S_FILL;
                end
            end

            if (cnt_clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (match && (cnt_q != '1)) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == '1) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign det_out   = det_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_fsm_bspd_param.sv
// Bench for fsm_bspd_param: a 4-bit/8-bit-counter instance and a 2-bit/2-bit-counter instance,
// both checked every cycle against a bit-window reference model, plus directed plan checks.
module tb_fsm_bspd_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_bv, a_bi, a_load, a_ov, a_clr;
    logic [3:0] a_pin;
    logic       a_det, a_sat;
    logic [7:0] a_cnt;
    logic       b_bv, b_bi, b_load, b_ov, b_clr;
    logic [1:0] b_pin;
    logic       b_det, b_sat;
    logic [1:0] b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fsm_bspd_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bit_in(a_bi), .bit_valid(a_bv), .pat_load(a_load),
        .pat_in(a_pin), .overlap_en(a_ov), .cnt_clr(a_clr),
        .det_out(a_det), .match_cnt(a_cnt), .cnt_sat(a_sat)
    );

    fsm_bspd_param #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bit_in(b_bi), .bit_valid(b_bv), .pat_load(b_load),
        .pat_in(b_pin), .overlap_en(b_ov), .cnt_clr(b_clr),
        .det_out(b_det), .match_cnt(b_cnt), .cnt_sat(b_sat)
    );

    // Reference model: pattern, number of valid bits seen since the last clear, and the last
    // pw bits seen as an integer window.
    int pw   [2] = '{4, 2};
    int cmax [2] = '{255, 3};
    int prst [2] = '{13, 3};
    int m_pat[2], m_seen[2], m_win[2], m_det[2], m_cnt[2], m_sat[2];

    function automatic void model_step(int m, bit rst, bit ld, int pin, bit bv, bit bi,
                                       bit ov, bit clr);
        int mask = (1 << pw[m]) - 1;
        int nw;
        bit hit;
        if (rst) begin
            m_pat[m] = prst[m]; m_seen[m] = 0; m_win[m] = 0;
            m_det[m] = 0; m_cnt[m] = 0; m_sat[m] = 0;
            return;
        end
        nw  = ((m_win[m] << 1) | int'(bi)) & mask;
        hit = !ld && bv && (m_seen[m] + 1 >= pw[m]) && (nw == m_pat[m]);
        m_det[m] = int'(hit);
        if (ld) begin
            m_pat[m] = pin; m_seen[m] = 0; m_win[m] = 0;
        end else if (bv) begin
            if (hit && !ov) begin
                m_seen[m] = 0; m_win[m] = 0;
            end else begin
                m_seen[m] = m_seen[m] + 1; m_win[m] = nw;
            end
        end
        if (clr) begin
            m_cnt[m] = 0; m_sat[m] = 0;
        end else if (hit && m_cnt[m] != cmax[m]) begin
            m_cnt[m] = m_cnt[m] + 1;
            if (m_cnt[m] == cmax[m]) m_sat[m] = 1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, reset, a_load, int'(a_pin), a_bv, a_bi, a_ov, a_clr);
        model_step(1, reset, b_load, int'(b_pin), b_bv, b_bi, b_ov, b_clr);
        #1;
        check("a_det", 32'(a_det), m_det[0]);
        check("a_cnt", 32'(a_cnt), m_cnt[0]);
        check("a_sat", 32'(a_sat), m_sat[0]);
        check("b_det", 32'(b_det), m_det[1]);
        check("b_cnt", 32'(b_cnt), m_cnt[1]);
        check("b_sat", 32'(b_sat), m_sat[1]);
    endtask

    task automatic feed_a(input bit b);
        a_bv = 1'b1; a_bi = b; tick(); a_bv = 1'b0;
    endtask

    task automatic feed_b(input bit b);
        b_bv = 1'b1; b_bi = b; tick(); b_bv = 1'b0;
    endtask

    task automatic load_a(input logic [3:0] p);
        a_load = 1'b1; a_pin = p; tick(); a_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_bv = 0; a_bi = 0; a_load = 0; a_ov = 1; a_clr = 0; a_pin = '0;
        b_bv = 0; b_bi = 0; b_load = 0; b_ov = 1; b_clr = 0; b_pin = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_det", 32'(a_det), 0);
        check("rst_cnt", 32'(a_cnt), 0);
        check("rst_sat", 32'(a_sat), 0);

        // Default pattern 1101.
        feed_a(1); check("p1_no_early", 32'(a_det), 0);
        feed_a(1); feed_a(0);
        check("p1_no_early3", 32'(a_det), 0);
        feed_a(1);
        check("p1_det", 32'(a_det), 1);
        check("p1_cnt", 32'(a_cnt), 1);
        tick();
        check("p1_one_cycle", 32'(a_det), 0);

        // 1010 with overlap, then without.
        a_ov = 1'b1;
        load_a(4'b1010);
        for (int i = 0; i < 8; i++) feed_a(bit'((i + 1) % 2));
        check("p2_ov_cnt", 32'(a_cnt), 4);
        a_ov = 1'b0;
        load_a(4'b1010);
        for (int i = 0; i < 8; i++) feed_a(bit'((i + 1) % 2));
        check("p2_nov_cnt", 32'(a_cnt), 6);

        // Valid gap in the middle of a pattern.
        load_a(4'b1101);
        feed_a(1); feed_a(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p3_gap_det", 32'(a_det), 0);
        end
        feed_a(0); feed_a(1);
        check("p3_det", 32'(a_det), 1);

        // Reload restarts history.
        load_a(4'b0000);
        feed_a(0); feed_a(0); feed_a(0);
        a_bv = 1'b1; a_bi = 1'b0; load_a(4'b0000);
        feed_a(0); feed_a(0); feed_a(0);
        check("p4_no_early", 32'(a_det), 0);
        feed_a(0);
        check("p4_det", 32'(a_det), 1);

        // Small counter saturation, then clear colliding with a match.
        for (int i = 0; i < 6; i++) feed_b(1);
        check("p5_cnt_sat_val", 32'(b_cnt), 3);
        check("p5_sat", 32'(b_sat), 1);
        b_clr = 1'b1; feed_b(1); b_clr = 1'b0;
        check("p5_clr_det", 32'(b_det), 1);
        check("p5_clr_cnt", 32'(b_cnt), 0);
        check("p5_clr_sat", 32'(b_sat), 0);

        // Reset in the middle of a pattern.
        load_a(4'b1101);
        feed_a(1); feed_a(1); feed_a(0);
        reset = 1'b1; a_bv = 1'b1; a_bi = 1'b1; tick();
        reset = 1'b0; a_bv = 1'b0;
        check("p6_det", 32'(a_det), 0);
        check("p6_cnt", 32'(a_cnt), 0);
        feed_a(1);
        check("p6_no_det", 32'(a_det), 0);
        feed_a(1); feed_a(0); feed_a(1);
        check("p6_full_det", 32'(a_det), 1);
        load_a(4'b0000);
        reset = 1'b1; tick(); reset = 1'b0;
        feed_a(1); feed_a(1); feed_a(0); feed_a(1);
        check("p6_pat_rst", 32'(a_det), 1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(199) == 0);
            a_bv   = ($urandom_range(3) != 0);
            a_bi   = 1'($urandom);
            a_load = ($urandom_range(29) == 0);
            a_pin  = 4'($urandom);
            a_clr  = ($urandom_range(49) == 0);
            if ($urandom_range(9) == 0) a_ov = ~a_ov;
            b_bv   = ($urandom_range(3) != 0);
            b_bi   = 1'($urandom);
            b_load = ($urandom_range(29) == 0);
            b_pin  = 2'($urandom);
            b_clr  = ($urandom_range(39) == 0);
            if ($urandom_range(9) == 0) b_ov = ~b_ov;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
